// File: rtl/mutative_dfp_arbiter_pkg.sv
// Shared types for the DFP arbiter: state encoding, requester IDs and line width.
package mutative_types;

    localparam int CACHELINE_SIZE = 256;
    localparam int DFP_ADDR_W     = 32;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_CACHE = 2'd1,
        A_FLUSH = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CACHE = 1'b0,
        REQ_FLUSH = 1'b1
    } req_id_e;

endpackage

// File: rtl/mutative_dfp_arbiter.sv
// Two-requester arbiter (cache, flush engine) in front of one DFP memory port.
// Define MUTATIVE_DFP_ARB_RR_EN for round-robin on contention; default is flush-first.
module mutative_dfp_arbiter
    import mutative_types::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cache_dfp_read,
    input  logic                      cache_dfp_write,
    input  logic [DFP_ADDR_W-1:0]     cache_dfp_addr,
    input  logic [CACHELINE_SIZE-1:0] cache_dfp_wdata,
    output logic [CACHELINE_SIZE-1:0] cache_dfp_rdata,
    output logic                      cache_dfp_resp,
    input  logic                      flush_dfp_write,
    input  logic [DFP_ADDR_W-1:0]     flush_dfp_addr,
    input  logic [CACHELINE_SIZE-1:0] flush_dfp_wdata,
    output logic                      flush_dfp_resp,
    output logic                      dfp_read,
    output logic                      dfp_write,
    output logic [DFP_ADDR_W-1:0]     dfp_addr,
    output logic [CACHELINE_SIZE-1:0] dfp_wdata,
    input  logic [CACHELINE_SIZE-1:0] dfp_rdata,
    input  logic                      dfp_resp,
    output logic                      arb_busy
);

    arb_state_e                state_q, state_d;
    logic                      read_q, read_d;
    logic                      write_q, write_d;
    logic [DFP_ADDR_W-1:0]     addr_q, addr_d;
    logic [CACHELINE_SIZE-1:0] wdata_q, wdata_d;
    logic                      cache_req;
    req_id_e                   winner;

`ifdef MUTATIVE_DFP_ARB_RR_EN
    req_id_e last_q, last_d;
`endif

    assign cache_req = cache_dfp_read | cache_dfp_write;

    always_comb begin
        winner = flush_dfp_write ? REQ_FLUSH : REQ_CACHE;
`ifdef MUTATIVE_DFP_ARB_RR_EN
        // On contention the requester that was not served last gets the grant.
        if (flush_dfp_write && cache_req) begin
            winner = (last_q == REQ_CACHE) ? REQ_FLUSH : REQ_CACHE;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef MUTATIVE_DFP_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            A_IDLE: begin
                if (cache_req || flush_dfp_write) begin
`ifdef MUTATIVE_DFP_ARB_RR_EN
                    last_d = winner;
`endif
                    if (winner == REQ_FLUSH) begin
                        state_d = A_FLUSH;
                        read_d  = 1'b0;
                        write_d = 1'b1;
                        addr_d  = flush_dfp_addr;
                        wdata_d = flush_dfp_wdata;
                    end else begin
                        // A combined read+write from the cache is a writeback only.
                        state_d = A_CACHE;
                        read_d  = ~cache_dfp_write;
                        write_d = cache_dfp_write;
                        addr_d  = cache_dfp_addr;
                        wdata_d = cache_dfp_wdata;
                    end
                end
            end
            A_CACHE, A_FLUSH: begin
                if (dfp_resp) begin
                    state_d = A_IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            default: begin
                state_d = A_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= A_IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MUTATIVE_DFP_ARB_RR_EN
            last_q  <= REQ_CACHE;
`endif
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef MUTATIVE_DFP_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign dfp_read        = read_q;
    assign dfp_write       = write_q;
    assign dfp_addr        = addr_q;
    assign dfp_wdata       = wdata_q;
    assign arb_busy        = (state_q != A_IDLE);
    // Completion is passed through combinationally so the owner sees it in the dfp_resp cycle.
    assign cache_dfp_resp  = (state_q == A_CACHE) && dfp_resp;
    assign flush_dfp_resp  = (state_q == A_FLUSH) && dfp_resp;
    assign cache_dfp_rdata = cache_dfp_resp ? dfp_rdata : '0;

endmodule

// File: tb/tb_mutative_dfp_arbiter.sv
// Scoreboarded bench for mutative_dfp_arbiter: a memory model checks each dfp request
// against queued expectations and a monitor checks the owner's completion.
module tb_mutative_dfp_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cache_dfp_read = 1'b0, cache_dfp_write = 1'b0;
    logic [31:0]  cache_dfp_addr = '0;
    logic [255:0] cache_dfp_wdata = '0, cache_dfp_rdata;
    logic         cache_dfp_resp;
    logic         flush_dfp_write = 1'b0;
    logic [31:0]  flush_dfp_addr = '0;
    logic [255:0] flush_dfp_wdata = '0;
    logic         flush_dfp_resp;
    logic         dfp_read, dfp_write;
    logic [31:0]  dfp_addr;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata = '0;
    logic         dfp_resp = 1'b0;
    logic         arb_busy;

    mutative_dfp_arbiter dut (
        .clk(clk), .rst(rst),
        .cache_dfp_read(cache_dfp_read), .cache_dfp_write(cache_dfp_write),
        .cache_dfp_addr(cache_dfp_addr), .cache_dfp_wdata(cache_dfp_wdata),
        .cache_dfp_rdata(cache_dfp_rdata), .cache_dfp_resp(cache_dfp_resp),
        .flush_dfp_write(flush_dfp_write), .flush_dfp_addr(flush_dfp_addr),
        .flush_dfp_wdata(flush_dfp_wdata), .flush_dfp_resp(flush_dfp_resp),
        .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_addr(dfp_addr),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         owner;   // 0 = cache, 1 = flush
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic         chk_gap;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         cur;
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           last_resp_cyc = 0;
    int           lat = 2;
    int           cnt = 0;
    int           done_cnt = 0;
    logic         seen = 1'b0;
    logic         hold = 1'b0;
    logic         spurious = 1'b0;
    logic         resp_spurious = 1'b0;
    logic [255:0] rdata_val = {32{8'hA5}};

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s = %0h (cycle %0d)", tag, got, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: checks each new request against the scoreboard, answers after lat cycles.
    always @(negedge clk) begin
        if (rst) begin
            dfp_resp = 1'b0; dfp_rdata = '0; seen = 1'b0; resp_spurious = 1'b0;
        end else if (dfp_resp) begin
            dfp_resp = 1'b0; dfp_rdata = '0; seen = 1'b0; resp_spurious = 1'b0;
        end else if (spurious) begin
            spurious = 1'b0; resp_spurious = 1'b1; dfp_resp = 1'b1; dfp_rdata = rdata_val;
        end else if (dfp_read || dfp_write) begin
            if (!seen) begin
                seen = 1'b1;
                cnt = 0;
                if (sb_q.size() == 0) begin
                    chk("unexpected_txn", 1, 0);
                end else begin
                    cur = sb_q.pop_front();
                    chk("op_write", dfp_write, cur.wr);
                    chk("op_read", dfp_read, !cur.wr);
                    chk("dfp_addr", dfp_addr, cur.addr);
                    if (cur.wr) chk("dfp_wdata", dfp_wdata, cur.wdata);
                    if (cur.chk_gap) chk("idle_gap", cyc - last_resp_cyc, 2);
                end
            end
            cnt++;
            if (cnt >= lat) begin
                dfp_resp = 1'b1; dfp_rdata = rdata_val; last_resp_cyc = cyc;
            end
        end
    end

    // Completion monitor: owner pulses, non-owner silent, requester drops its request.
    always @(negedge clk) begin
        #2;
        if (!rst && dfp_resp) begin
            if (resp_spurious) begin
                chk("idle_resp_cache", cache_dfp_resp, 0);
                chk("idle_resp_flush", flush_dfp_resp, 0);
            end else if (cur.owner == 1'b0) begin
                chk("cache_resp", cache_dfp_resp, 1);
                chk("flush_resp_nonowner", flush_dfp_resp, 0);
                chk("cache_rdata", cache_dfp_rdata, rdata_val);
                if (!hold) begin cache_dfp_read = 1'b0; cache_dfp_write = 1'b0; end
                done_cnt++;
            end else begin
                chk("flush_resp", flush_dfp_resp, 1);
                chk("cache_resp_nonowner", cache_dfp_resp, 0);
                chk("cache_rdata_nonowner", cache_dfp_rdata, 0);
                if (!hold) flush_dfp_write = 1'b0;
                done_cnt++;
            end
        end
    end

    task automatic push(input logic owner, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wdata, input logic gap);
        exp_t e;
        e.owner = owner; e.wr = wr; e.addr = addr; e.wdata = wdata; e.chk_gap = gap;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #3;
            if (sb_q.size() == 0 && !arb_busy && !dfp_resp && !cache_dfp_read &&
                !cache_dfp_write && !flush_dfp_write) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        bit got;
        int target;
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dfp_read", dfp_read, 0);
        chk("rst_dfp_write", dfp_write, 0);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_dfp_addr", dfp_addr, 0);
        chk("rst_cache_resp", cache_dfp_resp, 0);
        chk("rst_flush_resp", flush_dfp_resp, 0);
        chk("rst_cache_rdata", cache_dfp_rdata, 0);
        rst = 1'b0;

        // Single cache read, 1-cycle grant latency
        @(negedge clk);
        lat = 2;
        push(1'b0, 1'b0, 32'h0000_1000, '0, 1'b0);
        cache_dfp_read = 1'b1; cache_dfp_addr = 32'h0000_1000;
        #1;
        chk("grant_cycle_read", dfp_read, 0);
        chk("grant_cycle_busy", arb_busy, 0);
        @(negedge clk); #1;
        chk("lat1_dfp_read", dfp_read, 1);
        chk("lat1_arb_busy", arb_busy, 1);
        chk("lat1_dfp_addr", dfp_addr, 32'h0000_1000);
        wait_drain();

        // Simultaneous writes: flush first, cache after one idle cycle
        rdata_val = {32{8'h3C}};
        lat = 3;
        @(negedge clk);
        push(1'b1, 1'b1, 32'h0000_3000, {8{32'hF1F1_0003}}, 1'b0);
        push(1'b0, 1'b1, 32'h0000_2000, {8{32'hCAFE_0002}}, 1'b1);
        cache_dfp_write = 1'b1; cache_dfp_addr = 32'h0000_2000; cache_dfp_wdata = {8{32'hCAFE_0002}};
        flush_dfp_write = 1'b1; flush_dfp_addr = 32'h0000_3000; flush_dfp_wdata = {8{32'hF1F1_0003}};
        wait_drain();

        // Cache read+write together is treated as write only
        lat = 1;
        @(negedge clk);
        push(1'b0, 1'b1, 32'h0000_4000, {8{32'h1234_4000}}, 1'b0);
        cache_dfp_read = 1'b1; cache_dfp_write = 1'b1;
        cache_dfp_addr = 32'h0000_4000; cache_dfp_wdata = {8{32'h1234_4000}};
        wait_drain();

        // Requests held through four completions
        lat = 2;
        hold = 1'b1;
        @(negedge clk);
`ifdef MUTATIVE_DFP_ARB_RR_EN
        push(1'b1, 1'b1, 32'h0000_6000, {8{32'h6666_6666}}, 1'b0);
        push(1'b0, 1'b0, 32'h0000_5000, '0, 1'b1);
        push(1'b1, 1'b1, 32'h0000_6000, {8{32'h6666_6666}}, 1'b1);
        push(1'b0, 1'b0, 32'h0000_5000, '0, 1'b1);
`else
        push(1'b1, 1'b1, 32'h0000_6000, {8{32'h6666_6666}}, 1'b0);
        push(1'b1, 1'b1, 32'h0000_6000, {8{32'h6666_6666}}, 1'b1);
        push(1'b1, 1'b1, 32'h0000_6000, {8{32'h6666_6666}}, 1'b1);
        push(1'b1, 1'b1, 32'h0000_6000, {8{32'h6666_6666}}, 1'b1);
`endif
        target = done_cnt + 4;
        cache_dfp_read = 1'b1; cache_dfp_addr = 32'h0000_5000;
        flush_dfp_write = 1'b1; flush_dfp_addr = 32'h0000_6000; flush_dfp_wdata = {8{32'h6666_6666}};
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #3;
            if (done_cnt >= target) begin got = 1'b1; break; end
        end
        if (!got) chk("held_timeout", 0, 1);
        cache_dfp_read = 1'b0; flush_dfp_write = 1'b0;
        hold = 1'b0;
        wait_drain();

        // Cache request while flush owns the port is ignored until completion
        lat = 5;
        @(negedge clk);
        push(1'b1, 1'b1, 32'h0000_7000, {8{32'h7777_0000}}, 1'b0);
        push(1'b0, 1'b0, 32'h0000_8000, '0, 1'b1);
        flush_dfp_write = 1'b1; flush_dfp_addr = 32'h0000_7000; flush_dfp_wdata = {8{32'h7777_0000}};
        repeat (2) @(negedge clk);
        cache_dfp_read = 1'b1; cache_dfp_addr = 32'h0000_8000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("mid_dfp_addr", dfp_addr, 32'h0000_7000);
            chk("mid_cache_resp", cache_dfp_resp, 0);
        end
        wait_drain();

        // dfp_resp while idle produces no completion
        @(negedge clk); #3;
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_after_spurious", arb_busy, 0);

        // Reset in the middle of a cache writeback
        lat = 20;
        @(negedge clk);
        push(1'b0, 1'b1, 32'h0000_9000, {8{32'h9999_0000}}, 1'b0);
        cache_dfp_write = 1'b1; cache_dfp_addr = 32'h0000_9000; cache_dfp_wdata = {8{32'h9999_0000}};
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (dfp_write) begin got = 1'b1; break; end
        end
        chk("pre_rst_dfp_write", got, 1);
        rst = 1'b1;
        cache_dfp_write = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_dfp_write", dfp_write, 0);
        chk("post_rst_arb_busy", arb_busy, 0);
        chk("post_rst_cache_resp", cache_dfp_resp, 0);
        rst = 1'b0;
        sb_q.delete();

        // Contention after reset: pointer restarts at "cache last served"
        lat = 2;
        @(negedge clk);
        push(1'b1, 1'b1, 32'h0000_B000, {8{32'hBBBB_0000}}, 1'b0);
        push(1'b0, 1'b0, 32'h0000_A000, '0, 1'b1);
        cache_dfp_read = 1'b1; cache_dfp_addr = 32'h0000_A000;
        flush_dfp_write = 1'b1; flush_dfp_addr = 32'h0000_B000; flush_dfp_wdata = {8{32'hBBBB_0000}};
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
